// File: rtl/matmul_pkg.sv
// Shared types and indexing helpers for the matrix-multiply host and engine.
// Row-major element index: idx = row * n + col.
package matmul_pkg;

    localparam int unsigned MM_N  = 4;
    localparam int unsigned TOT   = MM_N * MM_N;
    localparam int unsigned CNT_W = $clog2(TOT + 1);

    typedef enum logic [2:0] {
        StLoadA,
        StLoadB,
        StRun,
        StRelease,
        StDrain
    } mm_state_t;

    function automatic int unsigned mm_row(input int unsigned idx, input int unsigned n);
        return idx / n;
    endfunction

    function automatic int unsigned mm_col(input int unsigned idx, input int unsigned n);
        return idx % n;
    endfunction

endpackage

// File: rtl/mm_elem_buffer.sv
// N x N element store: indexed write and read by flat row-major index,
// plus a full-matrix parallel load and parallel output.
module mm_elem_buffer #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 5
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_wr_en,
    input  logic [CNT_W-1:0]                 i_wr_idx,
    input  logic [DATA_W-1:0]                i_wr_data,
    input  logic                             i_ld_en,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_ld_mat,
    input  logic [CNT_W-1:0]                 i_rd_idx,
    output logic [DATA_W-1:0]                o_rd_data,
    output logic [N-1:0][N-1:0][DATA_W-1:0]  o_mat
);
    import matmul_pkg::*;

    localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0][N-1:0][DATA_W-1:0] r_mem;
    logic [RowW-1:0] w_wr_row, w_wr_col, w_rd_row, w_rd_col;

    assign w_wr_row = RowW'(mm_row(32'(i_wr_idx), N));
    assign w_wr_col = RowW'(mm_col(32'(i_wr_idx), N));
    assign w_rd_row = RowW'(mm_row(32'(i_rd_idx), N));
    assign w_rd_col = RowW'(mm_col(32'(i_rd_idx), N));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_ld_en) begin
            r_mem <= i_ld_mat;
        end else if (i_wr_en) begin
            r_mem[w_wr_row][w_wr_col] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[w_rd_row][w_rd_col];
    assign o_mat     = r_mem;

endmodule

// File: rtl/matmul_stream_host.sv
// Streams A then B into buffers, runs the engine start/done handshake,
// captures C and streams it back out row-major with a last marker.
module matmul_stream_host #(
    parameter int unsigned N      = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic                             out_last,
    output logic                             eng_start,
    output logic [N-1:0][N-1:0][DATA_W-1:0]  eng_a,
    output logic [N-1:0][N-1:0][DATA_W-1:0]  eng_b,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]  eng_c,
    input  logic                             eng_done,
    output logic                             busy
);
    import matmul_pkg::*;

    localparam int unsigned     Tot     = N * N;
    localparam int unsigned     CntW    = $clog2(Tot + 1);
    localparam logic [CntW-1:0] LastIdx = CntW'(Tot - 1);

    mm_state_t       r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic            r_start;
    logic            w_a_we, w_b_we, w_c_ld;
    logic [DATA_W-1:0] w_c_rd, w_unused_a_rd, w_unused_b_rd;
    logic [N-1:0][N-1:0][DATA_W-1:0] w_unused_c_mat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StLoadA;
            r_cnt   <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= (w_state_nxt == StRun);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_c_ld      = 1'b0;
        unique case (r_state)
            StLoadA, StLoadB: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (r_cnt == LastIdx) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_state == StLoadA) ? StLoadB : StRun;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
            end
            StRun: begin
                // A done level already high on entry counts as completion.
                if (eng_done) begin
                    w_c_ld      = 1'b1;
                    w_state_nxt = StRelease;
                end
            end
            StRelease: begin
                if (!eng_done) begin
                    w_state_nxt = StDrain;
                    w_cnt_nxt   = '0;
                end
            end
            StDrain: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_cnt == LastIdx) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = StLoadA;
                    end else begin
                        w_cnt_nxt = r_cnt + CntW'(1);
                    end
                end
            end
            default: w_state_nxt = StLoadA;
        endcase
    end

    assign w_a_we    = in_valid && (r_state == StLoadA);
    assign w_b_we    = in_valid && (r_state == StLoadB);
    assign out_data  = out_valid ? w_c_rd : '0;
    assign out_last  = out_valid && (r_cnt == LastIdx);
    assign eng_start = r_start;
    assign busy      = !((r_state == StLoadA) && (r_cnt == '0));

    mm_elem_buffer #(.N(N), .DATA_W(DATA_W), .CNT_W(CntW)) u_buf_a (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_a_we),
        .i_wr_idx  (r_cnt),
        .i_wr_data (in_data),
        .i_ld_en   (1'b0),
        .i_ld_mat  ('0),
        .i_rd_idx  (r_cnt),
        .o_rd_data (w_unused_a_rd),
        .o_mat     (eng_a)
    );

    mm_elem_buffer #(.N(N), .DATA_W(DATA_W), .CNT_W(CntW)) u_buf_b (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_b_we),
        .i_wr_idx  (r_cnt),
        .i_wr_data (in_data),
        .i_ld_en   (1'b0),
        .i_ld_mat  ('0),
        .i_rd_idx  (r_cnt),
        .o_rd_data (w_unused_b_rd),
        .o_mat     (eng_b)
    );

    mm_elem_buffer #(.N(N), .DATA_W(DATA_W), .CNT_W(CntW)) u_buf_c (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (1'b0),
        .i_wr_idx  ('0),
        .i_wr_data ('0),
        .i_ld_en   (w_c_ld),
        .i_ld_mat  (eng_c),
        .i_rd_idx  (r_cnt),
        .o_rd_data (w_c_rd),
        .o_mat     (w_unused_c_mat)
    );

endmodule

// File: tb/tb_matmul_stream_host.sv
// Directed bench for matmul_stream_host with a behavioural engine stub
// whose done delay is adjustable per test.
module tb_matmul_stream_host;

    localparam int N = 4;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic eng_start, eng_done, busy;
    logic [W-1:0] in_data, out_data;
    logic [N-1:0][N-1:0][W-1:0] eng_a, eng_b, eng_c;

    int n_cmp = 0;
    int n_bad = 0;
    int eng_delay = 3;
    int e_cnt;

    always #5 clk = ~clk;

    matmul_stream_host #(.N(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .eng_start (eng_start),
        .eng_a     (eng_a),
        .eng_b     (eng_b),
        .eng_c     (eng_c),
        .eng_done  (eng_done),
        .busy      (busy)
    );

    function automatic logic [N-1:0][N-1:0][W-1:0] mat_mul(
        input logic [N-1:0][N-1:0][W-1:0] a, input logic [N-1:0][N-1:0][W-1:0] b);
        logic [N-1:0][N-1:0][W-1:0] c;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < N; k++) c[i][j] = c[i][j] + a[i][k] * b[k][j];
            end
        return c;
    endfunction

    // Engine stub: done after eng_delay cycles of start, held until start drops,
    // then C is wiped so only a proper capture survives.
    always @(posedge clk) begin
        if (rst) begin
            eng_done <= 1'b0;
            e_cnt    <= 0;
            eng_c    <= '0;
        end else if (!eng_done) begin
            if (eng_start) begin
                if (e_cnt >= eng_delay) begin
                    eng_done <= 1'b1;
                    eng_c    <= mat_mul(eng_a, eng_b);
                end else begin
                    e_cnt <= e_cnt + 1;
                end
            end else begin
                e_cnt <= 0;
            end
        end else if (!eng_start) begin
            eng_done <= 1'b0;
            e_cnt    <= 0;
            eng_c    <= '0;
        end
    end

    task automatic push(input logic [W-1:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_cmp++; n_bad++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_ab(input logic [W-1:0] a[16], input logic [W-1:0] b[16]);
        for (int i = 0; i < 16; i++) push(a[i]);
        for (int i = 0; i < 16; i++) push(b[i]);
    endtask

    task automatic collect(input bit rnd, output logic [W-1:0] data[16],
                           output logic lasts[16], output int nhs, output int unstable,
                           output bit tmo);
        int t = 0;
        bit stalled = 1'b0;
        logic [W-1:0] held = '0;
        logic held_last = 1'b0;
        nhs = 0; unstable = 0; tmo = 1'b0;
        while (nhs < 16 && !tmo) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_ready && out_valid) unstable++;
            if (out_valid) begin
                if (stalled && (out_data !== held || out_last !== held_last)) unstable++;
                if (out_ready) begin
                    data[nhs]  = out_data;
                    lasts[nhs] = out_last;
                    nhs++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held      = out_data;
                    held_last = out_last;
                end
            end
            @(negedge clk);
            t++;
            if (t > 3000) tmo = 1'b1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, out_last, eng_start, busy} !== 5'b10000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy/vld/last/start/busy=%b required 10000",
                     {in_ready, out_valid, out_last, eng_start, busy});
        end
        n_cmp++;
        if (out_data !== '0 || eng_a !== '0 || eng_b !== '0) begin
            n_bad++;
            $display("FAIL reset_data: out_data=%h eng_a[0][0]=%h required 0",
                     out_data, eng_a[0][0]);
        end
    endtask

    task automatic test_identity;
        logic [W-1:0] a[16], b[16], got[16];
        logic lasts[16];
        int nhs, uns;
        bit tmo;
        for (int i = 0; i < 16; i++) begin
            a[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
            b[i] = 32'(i + 1);
        end
        eng_delay = 3;
        load_ab(a, b);
        n_cmp++;
        if (eng_start !== 1'b1 || eng_b[3][3] !== 32'd16 || eng_a[2][2] !== 32'd1) begin
            n_bad++;
            $display("FAIL ident_start: start=%b b33=%0d a22=%0d required 1/16/1",
                     eng_start, eng_b[3][3], eng_a[2][2]);
        end
        collect(1'b0, got, lasts, nhs, uns, tmo);
        n_cmp++;
        if (tmo || nhs != 16) begin
            n_bad++;
            $display("FAIL ident_count: got %0d handshakes required 16", nhs);
        end
        for (int i = 0; i < nhs; i++) begin
            n_cmp++;
            if (got[i] !== 32'(i + 1) || lasts[i] !== (i == 15)) begin
                n_bad++;
                $display("FAIL ident_elem%0d: got %0d last=%b required %0d last=%b",
                         i, got[i], lasts[i], i + 1, i == 15);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ident_busy: busy=%b required 0", busy);
        end
    endtask

    task automatic test_const_run_block;
        logic [W-1:0] a[16], b[16], got[16];
        logic lasts[16];
        int nhs, uns, bad, t;
        bit tmo;
        for (int i = 0; i < 16; i++) begin a[i] = 32'd2; b[i] = 32'd3; end
        load_ab(a, b);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        bad = 0; t = 0;
        while (!out_valid && t < 200) begin
            if (in_ready) bad++;
            @(negedge clk);
            t++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad != 0 || t >= 200) begin
            n_bad++;
            $display("FAIL run_block: in_ready high %0d cycles, wait=%0d, required 0", bad, t);
        end
        collect(1'b0, got, lasts, nhs, uns, tmo);
        n_cmp++;
        if (tmo || nhs != 16) begin
            n_bad++;
            $display("FAIL const_count: got %0d required 16", nhs);
        end
        for (int i = 0; i < nhs; i++) begin
            n_cmp++;
            if (got[i] !== 32'd24) begin
                n_bad++;
                $display("FAIL const_elem%0d: got %0d required 24", i, got[i]);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL const_no_consume: busy=%b required 0", busy);
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] a[16], b[16], got[16];
        logic lasts[16];
        int nhs, uns;
        bit tmo;
        for (int i = 0; i < 16; i++) begin a[i] = '0; b[i] = '0; end
        a[0] = 32'hFFFF_FFFF;
        b[0] = 32'hFFFF_FFFF;
        load_ab(a, b);
        collect(1'b1, got, lasts, nhs, uns, tmo);
        n_cmp++;
        if (tmo || nhs != 16) begin
            n_bad++;
            $display("FAIL stall_count: got %0d handshakes required 16", nhs);
        end
        n_cmp++;
        if (uns != 0) begin
            n_bad++;
            $display("FAIL stall_stable: %0d unstable/overlap cycles required 0", uns);
        end
        for (int i = 0; i < nhs; i++) begin
            n_cmp++;
            if (got[i] !== ((i == 0) ? 32'd1 : 32'd0) || lasts[i] !== (i == 15)) begin
                n_bad++;
                $display("FAIL stall_elem%0d: got %h last=%b required %h", i, got[i],
                         lasts[i], (i == 0) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic test_slow_engine;
        logic [W-1:0] a[16], b[16], got[16];
        logic lasts[16];
        int nhs, uns, hi, t;
        bit tmo;
        for (int i = 0; i < 16; i++) begin
            a[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
            b[i] = 32'd5;
        end
        eng_delay = 37;
        load_ab(a, b);
        hi = 0;
        while (eng_start && !eng_done && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        n_cmp++;
        if (hi != 38 || eng_done !== 1'b1 || eng_start !== 1'b1) begin
            n_bad++;
            $display("FAIL slow_start_hold: start held %0d cycles done=%b start=%b required 38/1/1",
                     hi, eng_done, eng_start);
        end
        @(negedge clk);
        n_cmp++;
        if (eng_start !== 1'b0) begin
            n_bad++;
            $display("FAIL slow_start_fall: eng_start=%b required 0", eng_start);
        end
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t < 1 || t >= 50 || eng_done !== 1'b0) begin
            n_bad++;
            $display("FAIL slow_valid_after_release: wait=%0d done=%b required done 0", t,
                     eng_done);
        end
        collect(1'b0, got, lasts, nhs, uns, tmo);
        n_cmp++;
        if (tmo || nhs != 16 || got[0] !== 32'd5 || got[15] !== 32'd5) begin
            n_bad++;
            $display("FAIL slow_data: n=%0d c00=%0d c33=%0d required 16/5/5", nhs, got[0],
                     got[15]);
        end
        eng_delay = 3;
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] a[16], b[16], got[16];
        logic lasts[16];
        int nhs, uns;
        bit tmo;
        for (int i = 0; i < 16; i++) push(32'd7);
        for (int i = 0; i < 5; i++) push(32'd9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: rdy=%b start=%b busy=%b required 1/0/0", in_ready,
                     eng_start, busy);
        end
        for (int i = 0; i < 16; i++) begin
            a[i] = 32'(i + 1);
            b[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
        end
        load_ab(a, b);
        collect(1'b0, got, lasts, nhs, uns, tmo);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (tmo || i >= nhs || got[i] !== 32'(i + 1)) begin
                n_bad++;
                $display("FAIL mid_elem%0d: got %0d required %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a[16], b[16], got[16];
        logic lasts[16];
        int nhs, uns;
        bit tmo;
        for (int i = 0; i < 16; i++) begin
            a[i] = (i % 5 == 0) ? 32'd1 : 32'd0;
            b[i] = 32'(100 + i);
        end
        load_ab(a, b);
        collect(1'b0, got, lasts, nhs, uns, tmo);
        n_cmp++;
        if (tmo || got[3] !== 32'd103) begin
            n_bad++;
            $display("FAIL b2b_pass1: c03=%0d required 103", got[3]);
        end
        for (int i = 0; i < 16; i++) begin
            a[i] = (i % 5 == 0) ? 32'd2 : 32'd0;
            b[i] = 32'(i + 1);
        end
        load_ab(a, b);
        collect(1'b0, got, lasts, nhs, uns, tmo);
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (tmo || i >= nhs || got[i] !== 32'(2 * (i + 1))) begin
                n_bad++;
                $display("FAIL b2b_elem%0d: got %0d required %0d", i, got[i], 2 * (i + 1));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_const_run_block();
        test_stall();
        test_slow_engine();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
